oflow_core_read_sequencer: RTL and testbench
============================================

# oflow_core_read_sequencer

Parametrised per-frame read sequencer in the oflow core. It steps through the sets of a frame, issues one `start_read` per set to the buffer-read FSM, and waits for `done_read` and then `done_registration` before moving to the next set. It also collects per-PE similarity-metric completions under an active-PE mask, so a short last set is handled correctly. It adds abort, zero-set frames, latched frame configuration and explicit status outputs.

## Interface

Parameters:

- `PE_NUM`, default 24: number of processing elements (PEs) / similarity-metric instances.
- `SET_LEN`, default 4: width of set count and set index.
- `REMAIN_LEN`, default `$clog2(PE_NUM+1)`: width of the last-set bbox count.

Ports:

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start_frame` in 1: one-cycle request to begin a frame; ignored while `busy`.
- `num_of_sets` in `SET_LEN`: number of sets in the frame; sampled on accepted `start_frame`.
- `remain_bboxes` in `REMAIN_LEN`: number of bboxes in the last set; 0 or any value above `PE_NUM` is treated as `PE_NUM`; sampled with `num_of_sets`.
- `abort` in 1: synchronous frame abort.
- `done_read` in 1: from the buffer-read FSM; current set fully read.
- `done_registration` in 1: from registration; current set registered.
- `done_similarity_metric_i` in `PE_NUM`: per-PE completion, level or pulse.
- `start_read` out 1: one-cycle pulse to the buffer-read FSM.
- `read_new_line` out 1: one-cycle pulse; all active PEs have finished the current line.
- `set_idx` out `SET_LEN`: index of the current set.
- `active_pe_mask` out `PE_NUM`: PEs valid in the current set.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse at normal frame completion.

## Operation

- States: IDLE, ISSUE, READ, WAIT_REG, DONE.
- IDLE:
  - On `start_frame`, latch `num_of_sets` and `remain_bboxes` and clear `set_idx`.
  - If `num_of_sets` is 0, go to DONE. Otherwise go to ISSUE.
- ISSUE: `start_read` = 1 in this state. Always go to READ after one cycle.
- READ:
  - Collect PE completions (see below).
  - On `done_read`, go to WAIT_REG.
- WAIT_REG: on `done_registration`:
  - If `set_idx` == latched sets − 1, go to DONE.
  - Otherwise increment `set_idx` and go to ISSUE.
- DONE: `frame_done` = 1. Always go to IDLE after one cycle.
- `done_registration` outside WAIT_REG and `done_read` outside READ are ignored; they are not queued.
- `active_pe_mask`:
  - All ones, except when `set_idx` == latched sets − 1.
  - In the last set, the low `remain_bboxes` bits are set.
- PE completion collection:
  - sticky <= sticky | (`done_similarity_metric_i` & mask), updated only in READ.
  - When (sticky | (`done_similarity_metric_i` & mask)) == mask, pulse `read_new_line` on the next cycle and clear sticky.
  - Completion from an inactive PE never contributes.
- Sticky is cleared on entering ISSUE, so lines never carry over between sets.
- `abort` in any non-IDLE state:
  - Go to IDLE next cycle and clear sticky and `set_idx`.
  - No `frame_done`. Any `start_read` or `read_new_line` pulse already scheduled is suppressed.
  - `abort` has priority over every other transition.

## Timing

- Reset values: state IDLE; all outputs 0; `active_pe_mask` 0; sticky 0.
- `start_read` is registered:
  - First set: high the cycle after `start_frame` is sampled.
  - Later sets: high the cycle after `done_registration` is sampled.
  - Always exactly one cycle wide.
- `read_new_line` latency is one cycle from the edge at which the last active PE completion is sampled.
- `frame_done` is high the cycle after the final `done_registration`, or the cycle after `start_frame` for a zero-set frame.
- `done_read` and the final PE completion in the same cycle: `read_new_line` still pulses, and the state moves to WAIT_REG.
- `set_idx` saturation is impossible: it is bounded by the latched `num_of_sets`, whose maximum is 2^`SET_LEN`−1.

## Structure

- Package `oflow_core_read_pkg` holds:
  - the state enum `read_seq_state_t`;
  - default parameter constants `PE_NUM`, `SET_LEN`;
  - function `last_set_mask(remain, PE_NUM)`.
- Sub-module `oflow_pe_done_collector`, parameterised by `PE_NUM`, holds the sticky register, the mask compare and the `read_new_line` pulse generation. Its inputs are enable, clear, mask and done.

## Test plan

- `num_of_sets`=3, `remain_bboxes`=24, one registration per set -> 3 `start_read` pulses, `set_idx` 0,1,2, one `frame_done` one cycle after the 3rd `done_registration`.
- `num_of_sets`=2, `remain_bboxes`=5:
  - In set 1, `active_pe_mask`=0x00001F.
  - PEs 0–4 finish on separate cycles and PEs 5–23 stay 0 -> single `read_new_line` one cycle after PE4.
- `num_of_sets`=0 -> no `start_read`, `frame_done` pulse one cycle after `start_frame`, `busy` high for exactly 1 cycle.
- `abort` asserted in READ during set 1 -> IDLE next cycle, `set_idx`=0, no `frame_done`. A new `start_frame` then restarts from set 0.
- `done_registration` asserted in READ and then not repeated -> FSM stays in WAIT_REG. Asserting `start_frame` while `busy` is ignored.
- `reset` asserted mid-WAIT_REG -> all outputs 0 immediately, asynchronously; after release, idle until `start_frame`.

Source files
------------

// File: rtl/oflow_core_read_pkg.sv
// Shared types, default sizes and helpers for the oflow core read sequencer.
package oflow_core_read_pkg;

  // Default sizes used by the sequencer and the PE completion collector.
  localparam int PE_NUM     = 24;
  localparam int SET_LEN    = 4;
  // Widest PE array the mask helper can describe.
  localparam int MAX_PE_NUM = 64;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_READ     = 3'd2,
    ST_WAIT_REG = 3'd3,
    ST_DONE     = 3'd4
  } read_seq_state_t;

  // Mask of PEs valid in the last set. A count of zero, or one larger than
  // the PE array, means the last set is full.
  function automatic logic [MAX_PE_NUM-1:0] last_set_mask(input int unsigned remain,
                                                          input int unsigned pe_num);
    int unsigned eff;
    eff = ((remain == 0) || (remain > pe_num)) ? pe_num : remain;
    if (eff >= MAX_PE_NUM) begin
      return '1;
    end
    return (MAX_PE_NUM'(1) << eff) - MAX_PE_NUM'(1);
  endfunction

endpackage

// File: rtl/oflow_core_read_sequencer_collector.sv
// Collects per-PE line completions under the active-PE mask and pulses
// read_new_line once every active PE has finished the current line.
module oflow_pe_done_collector #(
  parameter int PE_NUM = oflow_core_read_pkg::PE_NUM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [PE_NUM-1:0] mask,
  input  logic [PE_NUM-1:0] done,
  output logic              read_new_line
);

  logic [PE_NUM-1:0] sticky_q, sticky_d;
  logic              pulse_q, pulse_d;
  logic [PE_NUM-1:0] combined;

  // Merge new completions into the sticky set and detect a finished line.
  always_comb begin
    sticky_d = sticky_q;
    pulse_d  = 1'b0;
    combined = sticky_q | (done & mask);
    if (clear) begin
      sticky_d = '0;
    end else if (enable) begin
      if (combined == mask) begin
        sticky_d = '0;
        pulse_d  = 1'b1;
      end else begin
        sticky_d = combined;
      end
    end
  end

  // Sticky completion register and registered line-done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      pulse_q  <= pulse_d;
    end
  end

  assign read_new_line = pulse_q;

endmodule

// File: rtl/oflow_core_read_sequencer.sv
// Per-frame read sequencer: walks the sets of a frame, kicks the buffer-read
// FSM once per set and waits for read and registration completion.
module oflow_core_read_sequencer #(
  parameter int PE_NUM     = oflow_core_read_pkg::PE_NUM,
  parameter int SET_LEN    = oflow_core_read_pkg::SET_LEN,
  parameter int REMAIN_LEN = $clog2(PE_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_frame,
  input  logic [SET_LEN-1:0]    num_of_sets,
  input  logic [REMAIN_LEN-1:0] remain_bboxes,
  input  logic                  abort,
  input  logic                  done_read,
  input  logic                  done_registration,
  input  logic [PE_NUM-1:0]     done_similarity_metric_i,
  output logic                  start_read,
  output logic                  read_new_line,
  output logic [SET_LEN-1:0]    set_idx,
  output logic [PE_NUM-1:0]     active_pe_mask,
  output logic                  busy,
  output logic                  frame_done
);

  import oflow_core_read_pkg::*;

  read_seq_state_t       state_q, state_d;
  logic [SET_LEN-1:0]    set_idx_q, set_idx_d;
  logic [SET_LEN-1:0]    sets_q, sets_d;
  logic [REMAIN_LEN-1:0] remain_q, remain_d;
  logic                  is_last_set;
  logic                  abort_taken;
  logic                  collect_en;
  logic                  clear_sticky;
  logic [PE_NUM-1:0]     last_mask;
  logic [PE_NUM-1:0]     mask;

  assign is_last_set = (set_idx_q == (sets_q - SET_LEN'(1)));
  assign abort_taken = abort && (state_q != ST_IDLE);
  assign last_mask   = PE_NUM'(last_set_mask(32'(remain_q), PE_NUM));

  // Active-PE mask: only meaningful while a set is being worked on.
  always_comb begin
    mask = '0;
    if ((state_q == ST_ISSUE) || (state_q == ST_READ) || (state_q == ST_WAIT_REG)) begin
      mask = is_last_set ? last_mask : '1;
    end
  end

  // Next-state and frame configuration logic; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    set_idx_d = set_idx_q;
    sets_d    = sets_q;
    remain_d  = remain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_frame) begin
          sets_d    = num_of_sets;
          remain_d  = remain_bboxes;
          set_idx_d = '0;
          state_d   = (num_of_sets == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        if (done_read) begin
          state_d = ST_WAIT_REG;
        end
      end
      ST_WAIT_REG: begin
        if (done_registration) begin
          if (is_last_set) begin
            state_d = ST_DONE;
          end else begin
            set_idx_d = set_idx_q + SET_LEN'(1);
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort_taken) begin
      state_d   = ST_IDLE;
      set_idx_d = '0;
    end
  end

  // State, set index and latched frame configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      set_idx_q <= '0;
      sets_q    <= '0;
      remain_q  <= '0;
    end else begin
      state_q   <= state_d;
      set_idx_q <= set_idx_d;
      sets_q    <= sets_d;
      remain_q  <= remain_d;
    end
  end

  assign collect_en   = (state_q == ST_READ) && !abort_taken;
  assign clear_sticky = abort_taken || (state_d == ST_ISSUE);

  oflow_pe_done_collector #(
    .PE_NUM(PE_NUM)
  ) u_collector (
    .clk          (clk),
    .reset        (reset),
    .enable       (collect_en),
    .clear        (clear_sticky),
    .mask         (mask),
    .done         (done_similarity_metric_i),
    .read_new_line(read_new_line)
  );

  assign start_read     = (state_q == ST_ISSUE);
  assign frame_done     = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);
  assign set_idx        = set_idx_q;
  assign active_pe_mask = mask;

endmodule

// File: tb/tb_oflow_core_read_sequencer.sv
// Directed self-checking bench for the oflow core read sequencer.
module tb_oflow_core_read_sequencer;

  logic        clk;
  logic        reset;
  logic        start_frame;
  logic [3:0]  num_of_sets;
  logic [4:0]  remain_bboxes;
  logic        abort;
  logic        done_read;
  logic        done_registration;
  logic [23:0] done_similarity_metric_i;
  logic        start_read;
  logic        read_new_line;
  logic [3:0]  set_idx;
  logic [23:0] active_pe_mask;
  logic        busy;
  logic        frame_done;

  int testCount;
  int failCount;

  oflow_core_read_sequencer #(
    .PE_NUM    (24),
    .SET_LEN   (4),
    .REMAIN_LEN(5)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start_frame             (start_frame),
    .num_of_sets             (num_of_sets),
    .remain_bboxes           (remain_bboxes),
    .abort                   (abort),
    .done_read               (done_read),
    .done_registration       (done_registration),
    .done_similarity_metric_i(done_similarity_metric_i),
    .start_read              (start_read),
    .read_new_line           (read_new_line),
    .set_idx                 (set_idx),
    .active_pe_mask          (active_pe_mask),
    .busy                    (busy),
    .frame_done              (frame_done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hold one input vector across a single rising edge, then drop the pulses;
  // outputs are looked at 1 ns after that edge.
  task automatic applyStimulus(input logic sf, input logic ab, input logic dr,
                               input logic dreg, input logic [23:0] dsm);
    start_frame              = sf;
    abort                    = ab;
    done_read                = dr;
    done_registration        = dreg;
    done_similarity_metric_i = dsm;
    @(posedge clk);
    #1;
    start_frame              = 1'b0;
    abort                    = 1'b0;
    done_read                = 1'b0;
    done_registration        = 1'b0;
    done_similarity_metric_i = '0;
  endtask

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    testCount                = 0;
    failCount                = 0;
    reset                    = 1'b1;
    start_frame              = 1'b0;
    num_of_sets              = '0;
    remain_bboxes            = '0;
    abort                    = 1'b0;
    done_read                = 1'b0;
    done_registration        = 1'b0;
    done_similarity_metric_i = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_start_read", 32'(start_read), 32'd0);
    checkOutput("rst_read_new_line", 32'(read_new_line), 32'd0);
    checkOutput("rst_set_idx", 32'(set_idx), 32'd0);
    checkOutput("rst_mask", 32'(active_pe_mask), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;

    // Three full sets, one registration each.
    num_of_sets   = 4'd3;
    remain_bboxes = 5'd24;
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("t1_s0_start_read", 32'(start_read), 32'd1);
    checkOutput("t1_s0_set_idx", 32'(set_idx), 32'd0);
    checkOutput("t1_s0_busy", 32'(busy), 32'd1);
    checkOutput("t1_s0_mask", 32'(active_pe_mask), 32'hFFFFFF);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t1_s0_read_pulse_width", 32'(start_read), 32'd0);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("t1_s1_start_read", 32'(start_read), 32'd1);
    checkOutput("t1_s1_set_idx", 32'(set_idx), 32'd1);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("t1_s2_start_read", 32'(start_read), 32'd1);
    checkOutput("t1_s2_set_idx", 32'(set_idx), 32'd2);
    checkOutput("t1_s2_mask", 32'(active_pe_mask), 32'hFFFFFF);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, '0);
    checkOutput("t1_wait_no_frame_done", 32'(frame_done), 32'd0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("t1_frame_done", 32'(frame_done), 32'd1);
    checkOutput("t1_done_busy", 32'(busy), 32'd1);
    checkOutput("t1_done_no_read", 32'(start_read), 32'd0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t1_frame_done_width", 32'(frame_done), 32'd0);
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);

    // Short last set of 5 PEs: collection under the mask.
    num_of_sets   = 4'd2;
    remain_bboxes = 5'd5;
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("t2_s0_mask", 32'(active_pe_mask), 32'hFFFFFF);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("t2_s1_mask", 32'(active_pe_mask), 32'h00001F);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 24'hFFFFE0);
    checkOutput("t2_inactive_only", 32'(read_new_line), 32'd0);
    applyStimulus(0, 0, 0, 0, 24'h000001);
    applyStimulus(0, 0, 0, 0, 24'h000002);
    applyStimulus(0, 0, 0, 0, 24'h000004);
    applyStimulus(0, 0, 0, 0, 24'h800008);
    checkOutput("t2_pe3_no_line", 32'(read_new_line), 32'd0);
    applyStimulus(0, 0, 0, 0, 24'h000010);
    checkOutput("t2_pe4_line", 32'(read_new_line), 32'd1);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t2_line_width", 32'(read_new_line), 32'd0);
    applyStimulus(0, 0, 0, 0, 24'h00000F);
    checkOutput("t2_line2_partial", 32'(read_new_line), 32'd0);
    applyStimulus(0, 0, 1, 0, 24'h000010);
    checkOutput("t2_line_with_done_read", 32'(read_new_line), 32'd1);
    checkOutput("t2_wait_no_read", 32'(start_read), 32'd0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("t2_frame_done", 32'(frame_done), 32'd1);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t2_idle", 32'(busy), 32'd0);

    // Zero-set frame.
    num_of_sets   = 4'd0;
    remain_bboxes = 5'd0;
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("t3_frame_done", 32'(frame_done), 32'd1);
    checkOutput("t3_busy", 32'(busy), 32'd1);
    checkOutput("t3_no_read", 32'(start_read), 32'd0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t3_busy_one_cycle", 32'(busy), 32'd0);
    checkOutput("t3_frame_done_width", 32'(frame_done), 32'd0);
    checkOutput("t3_still_no_read", 32'(start_read), 32'd0);

    // Abort in READ of set 1, with a line completing in the same cycle.
    num_of_sets   = 4'd2;
    remain_bboxes = 5'd30;
    applyStimulus(1, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t4_read_set_idx", 32'(set_idx), 32'd1);
    checkOutput("t4_oversize_remain_mask", 32'(active_pe_mask), 32'hFFFFFF);
    applyStimulus(0, 1, 0, 0, 24'hFFFFFF);
    checkOutput("t4_abort_busy", 32'(busy), 32'd0);
    checkOutput("t4_abort_set_idx", 32'(set_idx), 32'd0);
    checkOutput("t4_abort_no_frame_done", 32'(frame_done), 32'd0);
    checkOutput("t4_abort_no_line", 32'(read_new_line), 32'd0);
    checkOutput("t4_abort_mask", 32'(active_pe_mask), 32'd0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t4_after_no_frame_done", 32'(frame_done), 32'd0);
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("t4_restart_read", 32'(start_read), 32'd1);
    checkOutput("t4_restart_set_idx", 32'(set_idx), 32'd0);
    applyStimulus(0, 1, 0, 0, '0);
    checkOutput("t4_abort_from_issue", 32'(busy), 32'd0);

    // Early registration is not queued; start_frame while busy is ignored.
    num_of_sets   = 4'd2;
    remain_bboxes = 5'd0;
    applyStimulus(1, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("t5_early_reg_no_read", 32'(start_read), 32'd0);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t5_wait_busy", 32'(busy), 32'd1);
    checkOutput("t5_wait_no_read", 32'(start_read), 32'd0);
    checkOutput("t5_wait_no_done", 32'(frame_done), 32'd0);
    num_of_sets = 4'd0;
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("t5_busy_start_no_done", 32'(frame_done), 32'd0);
    checkOutput("t5_busy_start_no_read", 32'(start_read), 32'd0);
    checkOutput("t5_busy_start_set_idx", 32'(set_idx), 32'd0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("t5_s1_read", 32'(start_read), 32'd1);
    checkOutput("t5_s1_set_idx", 32'(set_idx), 32'd1);
    checkOutput("t5_zero_remain_mask", 32'(active_pe_mask), 32'hFFFFFF);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);
    checkOutput("t5_frame_done", 32'(frame_done), 32'd1);
    applyStimulus(0, 0, 0, 0, '0);

    // Asynchronous reset in WAIT_REG of the short last set.
    num_of_sets   = 4'd2;
    remain_bboxes = 5'd5;
    applyStimulus(1, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, '0);
    checkOutput("t6_pre_reset_mask", 32'(active_pe_mask), 32'h00001F);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_busy", 32'(busy), 32'd0);
    checkOutput("t6_async_set_idx", 32'(set_idx), 32'd0);
    checkOutput("t6_async_mask", 32'(active_pe_mask), 32'd0);
    checkOutput("t6_async_start_read", 32'(start_read), 32'd0);
    checkOutput("t6_async_frame_done", 32'(frame_done), 32'd0);
    checkOutput("t6_async_line", 32'(read_new_line), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, '0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t6_idle_busy", 32'(busy), 32'd0);
    checkOutput("t6_idle_no_read", 32'(start_read), 32'd0);
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("t6_restart_read", 32'(start_read), 32'd1);
    checkOutput("t6_restart_set_idx", 32'(set_idx), 32'd0);
    applyStimulus(0, 1, 0, 0, '0);
    checkOutput("t6_final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
